// File: rtl/scan_decoder.sv
// scan_decoder: registered 1-of-2^SEL_W decoder with active-low enable and
// active-low strobes, plus an autonomous scan mode that steps the active
// position every div+1 clocks and flags each N-1 -> 0 rollover on wrap.
module scan_decoder #(
  parameter int SEL_W = 2,
  parameter int DIV_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    g_l,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DIV_W-1:0]        div,
  output logic [(1<<SEL_W)-1:0]   y_l,
  output logic [SEL_W-1:0]        idx,
  output logic                    wrap
);

  logic [DIV_W-1:0] pcnt;
  logic             en_q;

  // Index, prescaler, enable and wrap state. In scan mode the >= compare
  // lets a freshly lowered div take effect on the very next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      pcnt <= '0;
      en_q <= 1'b0;
      wrap <= 1'b0;
    end else begin
      en_q <= ~g_l;
      if (!mode) begin
        idx  <= sel;
        pcnt <= '0;
        wrap <= 1'b0;
      end else if (g_l) begin
        // paused: hold position and prescaler so resume continues seamlessly
        wrap <= 1'b0;
      end else if (pcnt >= div) begin
        pcnt <= '0;
        idx  <= idx + SEL_W'(1);
        wrap <= &idx;
      end else begin
        pcnt <= pcnt + DIV_W'(1);
        wrap <= 1'b0;
      end
    end
  end

  // Strobes decode purely from registered state, so inputs never reach y_l
  // combinationally.
  always_comb begin
    y_l = '1;
    if (en_q) y_l[idx] = 1'b0;
  end

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed stimulus with literal expectations, plus a
// per-cycle comparison against a cycle-level behavioural model.
module tb_scan_decoder;

  localparam int SEL_W = 2;
  localparam int DIV_W = 16;
  localparam int N     = 1 << SEL_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             g_l;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [DIV_W-1:0] div;
  logic [N-1:0]     y_l;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  int checks   = 0;
  int failures = 0;

  scan_decoder #(.SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .g_l(g_l), .mode(mode), .sel(sel), .div(div),
    .y_l(y_l), .idx(idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: active position, cycles spent at it, enable, wrap flag.
  int m_pos, m_dwell, m_en, m_wrap;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_pos = 0; m_dwell = 0; m_en = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (mode == 1'b0) begin
        m_pos = int'(sel); m_dwell = 0;
      end else if (g_l == 1'b0) begin
        // a position is held for div+1 enabled cycles in total
        if (m_dwell >= int'(div)) begin
          m_wrap  = (m_pos == N - 1) ? 1 : 0;
          m_pos   = (m_pos + 1) % N;
          m_dwell = 0;
        end else begin
          m_dwell = m_dwell + 1;
        end
      end
      m_en = (g_l == 1'b0) ? 1 : 0;
    end
    m_valid = 1'b1;
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [N-1:0] ey;
      for (int k = 0; k < N; k++) ey[k] = !(m_en != 0 && k == m_pos);
      chk("model_y_l",  32'(y_l),  32'(ey));
      chk("model_idx",  32'(idx),  32'(m_pos));
      chk("model_wrap", 32'(wrap), 32'(m_wrap));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; g_l = 1'b0; sel = 2'd2; div = '0;
    tick(); tick();
    chk("rst_y_l", 32'(y_l), 32'b1111);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_wrap", 32'(wrap), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_y_l", 32'(y_l), 32'b1011);
    chk("post_rst_idx", 32'(idx), 2);

    // direct sweep
    sel = 2'd0; tick(); chk("dir0", 32'(y_l), 32'b1110);
    sel = 2'd1; tick(); chk("dir1", 32'(y_l), 32'b1101);
    sel = 2'd2; tick(); chk("dir2", 32'(y_l), 32'b1011);
    sel = 2'd3; tick(); chk("dir3", 32'(y_l), 32'b0111);
    g_l = 1'b1; tick();
    chk("dir_blank_y_l", 32'(y_l), 32'b1111);
    chk("dir_blank_idx", 32'(idx), 3);

    // scan div=2 from idx 0: idx steps every 3 edges, wrap on return to 0
    g_l = 1'b0; sel = 2'd0; tick();
    chk("scan_start_idx", 32'(idx), 0);
    mode = 1'b1; div = 16'd2;
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk("scan_idx", 32'(idx), 32'((k / 3) % 4));
      chk("scan_wrap", 32'(wrap), 32'((k % 12) == 0));
    end

    // pause/resume: div=3, pause after pcnt reaches 1
    div = 16'd3; tick();
    chk("pause_pre_idx", 32'(idx), 0);
    g_l = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("pause_y_l", 32'(y_l), 32'b1111);
      chk("pause_idx", 32'(idx), 0);
    end
    g_l = 1'b0;
    tick(); chk("resume1_y_l", 32'(y_l), 32'b1110);
    tick(); chk("resume2_idx", 32'(idx), 0);
    tick(); chk("resume3_idx", 32'(idx), 1);

    // div lowered below current count
    div = 16'd10;
    for (int k = 0; k < 7; k++) tick();
    chk("lower_pre_idx", 32'(idx), 1);
    div = 16'd4; tick();
    chk("lower_adv_idx", 32'(idx), 2);
    for (int k = 0; k < 4; k++) begin
      tick(); chk("lower_hold_idx", 32'(idx), 2);
    end
    tick(); chk("lower_next_idx", 32'(idx), 3);

    // reset mid-scan with div=0
    mode = 1'b0; sel = 2'd3; tick();
    chk("midrst_pre_idx", 32'(idx), 3);
    mode = 1'b1; div = 16'd0; reset = 1'b1; tick();
    chk("midrst_idx", 32'(idx), 0);
    chk("midrst_y_l", 32'(y_l), 32'b1111);
    reset = 1'b0; tick();
    chk("midrst_rel_idx", 32'(idx), 1);
    chk("midrst_rel_y_l", 32'(y_l), 32'b1101);
    tick(); tick();
    chk("div0_y_l", 32'(y_l), 32'b0111);
    tick();
    chk("div0_wrap", 32'(wrap), 1);
    chk("div0_idx", 32'(idx), 0);
    tick();
    chk("div0_wrap_clr", 32'(wrap), 0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
